// File: rtl/alu_seq_mdu.sv
// Registered ALU with shifts, iterative multiply and an optional iterative divide.
// Define ALU_DIV_EN to build the divider (ops C/D); otherwise C/D are illegal.
module alu_seq_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             div_zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NOT  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_EQU  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_MULU = 4'hB;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'hC;
    localparam logic [3:0] OP_REMU = 4'hD;

    typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
`endif

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic             last;
    logic             slot_free;
    logic             accept;
    logic             multi;

    logic             sub_like;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_next;

    logic             wr;
    logic [WIDTH-1:0] wr_res;
    logic             wr_cout;
    logic             wr_ovf;
    logic             wr_dz;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !rst && state == IDLE && slot_free;
    assign accept    = in_valid && in_ready;
    assign last      = cnt == LAST;

`ifdef ALU_DIV_EN
    assign multi = op == OP_MULU || op == OP_DIVU || op == OP_REMU;
`else
    assign multi = op == OP_MULU;
`endif

    // SUB, SLT and EQU all share the a + ~b + 1 adder path
    assign sub_like = op == OP_SUB || op == OP_SLT || op == OP_EQU;
    assign bx  = sub_like ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub_like};
    assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sh  = b[SHW-1:0];

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = ovf;
            end
            OP_NOT: alu_res = ~a;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLT: begin
                alu_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
                alu_cout = sum[WIDTH];
                alu_ovf  = ovf;
            end
            OP_EQU: begin
                alu_res  = {{(WIDTH-1){1'b0}}, a == b};
                alu_cout = sum[WIDTH];
            end
            OP_SLL: alu_res = a << sh;
            OP_SRL: alu_res = a >> sh;
            OP_SRA: alu_res = $signed(a) >>> sh;
            default: ;
        endcase
    end

    assign mul_next = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dr;
    logic [WIDTH-1:0] dd;
    logic             is_rem;
    logic             is_div;
    logic             dz;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] dq_next;
    logic [WIDTH-1:0] dr_next;
    logic [WIDTH-1:0] div_fin;
    logic [WIDTH-1:0] div_held;

    // dq starts as the dividend and fills with quotient bits from the right
    assign trial    = {dr, dq[WIDTH-1]};
    assign diff     = trial - {1'b0, dd};
    assign ge       = !diff[WIDTH];
    assign dr_next  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dq_next  = {dq[WIDTH-2:0], ge};
    assign div_fin  = is_rem ? dr_next : dq_next;
    assign div_held = is_rem ? dr : dq;
`endif

    always_comb begin
        wr      = 1'b0;
        wr_res  = alu_res;
        wr_cout = alu_cout;
        wr_ovf  = alu_ovf;
        wr_dz   = 1'b0;
        case (state)
            IDLE: wr = accept && !multi;
            MUL: begin
                if (last && slot_free) begin
                    wr      = 1'b1;
                    wr_res  = mul_next;
                    wr_cout = 1'b0;
                    wr_ovf  = 1'b0;
                end
            end
`ifdef ALU_DIV_EN
            DIV: begin
                if (last && slot_free) begin
                    wr      = 1'b1;
                    wr_res  = div_fin;
                    wr_cout = 1'b0;
                    wr_ovf  = 1'b0;
                    wr_dz   = dz;
                end
            end
`endif
            HOLD: begin
                if (slot_free) begin
                    wr      = 1'b1;
                    wr_cout = 1'b0;
                    wr_ovf  = 1'b0;
`ifdef ALU_DIV_EN
                    wr_res  = is_div ? div_held : acc;
                    wr_dz   = is_div && dz;
`else
                    wr_res  = acc;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
`ifdef ALU_DIV_EN
            dq        <= '0;
            dr        <= '0;
            dd        <= '0;
            is_rem    <= 1'b0;
            is_div    <= 1'b0;
            dz        <= 1'b0;
`endif
        end else begin
            if (wr) begin
                out_valid <= 1'b1;
                result    <= wr_res;
                zero      <= wr_res == '0;
                cout      <= wr_cout;
                overflow  <= wr_ovf;
                div_zero  <= wr_dz;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && op == OP_MULU) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef ALU_DIV_EN
                        is_div <= 1'b0;
                        dz     <= 1'b0;
`endif
                        state  <= MUL;
                    end
`ifdef ALU_DIV_EN
                    else if (accept && multi) begin
                        dq     <= a;
                        dr     <= '0;
                        dd     <= b;
                        is_rem <= op == OP_REMU;
                        is_div <= 1'b1;
                        dz     <= b == '0;
                        cnt    <= '0;
                        state  <= DIV;
                    end
`endif
                end
                MUL: begin
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (last) begin
                        cnt   <= '0;
                        state <= slot_free ? IDLE : HOLD;
                    end
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    dq  <= dq_next;
                    dr  <= dr_next;
                    cnt <= cnt + SHW'(1);
                    if (last) begin
                        cnt   <= '0;
                        state <= slot_free ? IDLE : HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (slot_free) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
